// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit Mini-SRC datapath.
//   Holds R0-R15, PC, IR, MAR, MDR, Y, Z (64-bit), HI, LO, input/output ports,
//   the CON flip-flop, the ALU and a word-addressed internal RAM.
// Ports:
//   clk, clr          clock, asynchronous active-high clear
//   read, write       RAM -> MDR path select / MDR -> RAM write strobe
//   *out              bus drive selects (fixed priority, see bus mux)
//   *In, IncPC        register load enables / PC-increment ALU op
//   Gra/Grb/Grc       register-field selects from IR; RIn/Rout/BAout use them
//   add..orSignal     ALU op selects
//   in_port_data      external input-port data
//   bus               current bus value
//   pc_q, ir_q        PC and IR contents
//   out_port          output-port register
//   con_q             CON flip-flop
module cpu_datapath #(
  parameter int    MEM_DEPTH = 512,
  parameter string MEM_INIT  = ""
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic        IN_Portout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        MARIn,
  input  logic        PCIn,
  input  logic        MDRIn,
  input  logic        IRIn,
  input  logic        YIn,
  input  logic        IncPC,
  input  logic        HiIn,
  input  logic        LoIn,
  input  logic        CIn,
  input  logic        InIn,
  input  logic        OutIn,
  input  logic        ZIn,
  input  logic        CONIn,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        RIn,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        add,
  input  logic        subtract,
  input  logic        multiply,
  input  logic        divide,
  input  logic        andSignal,
  input  logic        orSignal,
  input  logic [31:0] in_port_data,
  output logic [31:0] bus,
  output logic [31:0] pc_q,
  output logic [31:0] ir_q,
  output logic [31:0] out_port,
  output logic        con_q
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [15:0][31:0] rf_q;
  logic [31:0] mar_q, mdr_q, y_q, hi_q, lo_q, inport_q, outport_q;
  logic [63:0] z_q;
  logic [31:0] mem [MEM_DEPTH];

  logic [3:0]  ridx;
  logic [31:0] c_val, mdr_d;
  logic [63:0] alu_r;
  logic        con_d;
  logic signed [63:0] sa, sb, prod64, quo64, rem64;

  // RAM powers up zeroed.
  initial for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;

  assign out_port = outport_q;

  // Register index is the OR of whichever IR fields are enabled.
  assign ridx  = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
  assign c_val = {{13{ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    bus = '0;
    if (Rout || BAout)    bus = (BAout && ridx == 4'd0) ? 32'd0 : rf_q[ridx];
    else if (PCout)       bus = pc_q;
    else if (MDRout)      bus = mdr_q;
    else if (Zlowout)     bus = z_q[31:0];
    else if (Zhighout)    bus = z_q[63:32];
    else if (HIout)       bus = hi_q;
    else if (LOout)       bus = lo_q;
    else if (IN_Portout)  bus = inport_q;
    else if (Cout)        bus = c_val;
  end

  // Signed mul/div done at 64 bits on sign-extended operands so that
  // -2^31 / -1 has a defined (wrapped) result.
  assign sa     = {{32{y_q[31]}}, y_q};
  assign sb     = {{32{bus[31]}}, bus};
  assign prod64 = sa * sb;
  assign quo64  = sa / sb;
  assign rem64  = sa % sb;

  always_comb begin
    alu_r = {32'd0, bus};
    if (IncPC)          alu_r = {32'd0, bus + 32'd1};
    else if (add)       alu_r = {32'd0, y_q + bus};
    else if (subtract)  alu_r = {32'd0, y_q - bus};
    else if (multiply)  alu_r = prod64;
    else if (divide)    alu_r = (bus == 32'd0) ? {y_q, 32'hFFFF_FFFF} : {rem64[31:0], quo64[31:0]};
    else if (andSignal) alu_r = {32'd0, y_q & bus};
    else if (orSignal)  alu_r = {32'd0, y_q | bus};
  end

  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00: con_d = (bus == 32'd0);
      2'b01: con_d = (bus != 32'd0);
      2'b10: con_d = ~bus[31];
      2'b11: con_d = bus[31];
    endcase
  end

  assign mdr_d = read ? mem[mar_q[AW-1:0]] : bus;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      rf_q      <= '0;
      con_q     <= 1'b0;
    end else begin
      if (PCIn)         pc_q      <= bus;
      if (IRIn)         ir_q      <= bus;
      if (MARIn)        mar_q     <= bus;
      if (MDRIn)        mdr_q     <= mdr_d;
      if (YIn)          y_q       <= bus;
      if (ZIn || IncPC) z_q       <= alu_r;
      if (HiIn)         hi_q      <= bus;
      if (LoIn)         lo_q      <= bus;
      if (InIn)         inport_q  <= in_port_data;
      if (OutIn)        outport_q <= bus;
      if (RIn)          rf_q[ridx] <= bus;
      if (CONIn)        con_q     <= con_d;
    end
  end

  // RAM contents survive clr; only the write itself is held off.
  always_ff @(posedge clk) begin
    if (write && !clr) mem[mar_q[AW-1:0]] <= mdr_q;
  end

  // C is combinational from IR, so CIn has nothing to load.
  logic unused_ok;
  assign unused_ok = &{1'b0, CIn, mar_q[31:AW], quo64[63:32], rem64[63:32]};

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed T-state sequences plus random strobe patterns,
// each cycle checked against a behavioural model of the datapath.
module tb_cpu_datapath;
  typedef struct packed {
    logic read, write, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
    logic MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn;
    logic Gra, Grb, Grc, RIn, Rout, BAout;
    logic add, subtract, multiply, divide, andSignal, orSignal;
  } ctl_t;

  logic clk = 1'b0;
  logic clr;
  ctl_t c;
  logic [31:0] in_port_data;
  logic [31:0] bus, pc_q, ir_q, out_port;
  logic con_q;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .clr(clr), .read(c.read), .write(c.write),
    .PCout(c.PCout), .Zlowout(c.Zlowout), .Zhighout(c.Zhighout), .MDRout(c.MDRout),
    .Cout(c.Cout), .IN_Portout(c.IN_Portout), .LOout(c.LOout), .HIout(c.HIout),
    .MARIn(c.MARIn), .PCIn(c.PCIn), .MDRIn(c.MDRIn), .IRIn(c.IRIn), .YIn(c.YIn),
    .IncPC(c.IncPC), .HiIn(c.HiIn), .LoIn(c.LoIn), .CIn(c.CIn), .InIn(c.InIn),
    .OutIn(c.OutIn), .ZIn(c.ZIn), .CONIn(c.CONIn), .Gra(c.Gra), .Grb(c.Grb), .Grc(c.Grc),
    .RIn(c.RIn), .Rout(c.Rout), .BAout(c.BAout), .add(c.add), .subtract(c.subtract),
    .multiply(c.multiply), .divide(c.divide), .andSignal(c.andSignal), .orSignal(c.orSignal),
    .in_port_data(in_port_data), .bus(bus), .pc_q(pc_q), .ir_q(ir_q),
    .out_port(out_port), .con_q(con_q)
  );

  // behavioural model state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_inp, m_outp;
  logic [63:0] m_z;
  logic        m_con;
  logic [31:0] m_mem [512];

  int total = 0;
  int bad   = 0;
  logic [31:0] bus_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;
    m_hi = '0; m_lo = '0; m_inp = '0; m_outp = '0; m_con = 1'b0;
  endtask

  function automatic logic [3:0] m_idx(input ctl_t k);
    logic [3:0] r;
    r = 4'd0;
    if (k.Gra) r = r | m_ir[26:23];
    if (k.Grb) r = r | m_ir[22:19];
    if (k.Grc) r = r | m_ir[18:15];
    return r;
  endfunction

  function automatic logic [31:0] m_bus(input ctl_t k);
    logic [3:0] ri;
    ri = m_idx(k);
    if (k.Rout || k.BAout) return (k.BAout && ri == 4'd0) ? 32'd0 : m_r[ri];
    if (k.PCout)      return m_pc;
    if (k.MDRout)     return m_mdr;
    if (k.Zlowout)    return m_z[31:0];
    if (k.Zhighout)   return m_z[63:32];
    if (k.HIout)      return m_hi;
    if (k.LOout)      return m_lo;
    if (k.IN_Portout) return m_inp;
    if (k.Cout)       return {{13{m_ir[18]}}, m_ir[18:0]};
    return 32'd0;
  endfunction

  task automatic m_step(input ctl_t k, input logic [31:0] din, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    logic [3:0] ri;
    logic cn;
    logic [31:0] rd;
    sa = longint'($signed(m_y));
    sb = longint'($signed(b));
    if (k.IncPC)          res = {32'd0, b + 32'd1};
    else if (k.add)       res = {32'd0, m_y + b};
    else if (k.subtract)  res = {32'd0, m_y - b};
    else if (k.multiply)  res = sa * sb;
    else if (k.divide) begin
      if (b == 32'd0) res = {m_y, 32'hFFFF_FFFF};
      else begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
    end
    else if (k.andSignal) res = {32'd0, m_y & b};
    else if (k.orSignal)  res = {32'd0, m_y | b};
    else                  res = {32'd0, b};
    case (m_ir[20:19])
      2'b00:   cn = (b == 32'd0);
      2'b01:   cn = (b != 32'd0);
      2'b10:   cn = ($signed(b) >= 0);
      default: cn = ($signed(b) < 0);
    endcase
    ri = m_idx(k);
    rd = m_mem[m_mar[8:0]];
    if (k.write)            m_mem[m_mar[8:0]] = m_mdr;
    if (k.MDRIn)            m_mdr = k.read ? rd : b;
    if (k.PCIn)             m_pc = b;
    if (k.IRIn)             m_ir = b;
    if (k.MARIn)            m_mar = b;
    if (k.YIn)              m_y = b;
    if (k.ZIn || k.IncPC)   m_z = res;
    if (k.HiIn)             m_hi = b;
    if (k.LoIn)             m_lo = b;
    if (k.InIn)             m_inp = din;
    if (k.OutIn)            m_outp = b;
    if (k.RIn)              m_r[ri] = b;
    if (k.CONIn)            m_con = cn;
  endtask

  task automatic cyc(input ctl_t k, input logic [31:0] din);
    logic [31:0] eb;
    @(negedge clk);
    c = k;
    in_port_data = din;
    #1;
    bus_seen = bus;
    eb = m_bus(k);
    chk("bus", bus, eb);
    m_step(k, din, eb);
    @(posedge clk);
    #1;
    chk("pc", pc_q, m_pc);
    chk("ir", ir_q, m_ir);
    chk("out_port", out_port, m_outp);
    chk("con", con_q, m_con);
  endtask

  // Load a value through the input port, then drive it onto the bus with extra strobes.
  task automatic put(input logic [31:0] v, input ctl_t tgt);
    ctl_t k;
    k = '0; k.InIn = 1'b1;
    cyc(k, v);
    tgt.IN_Portout = 1'b1;
    cyc(tgt, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    c = '0;
    #2;
    clr = 1'b1;
    #1;
    chk("rst_pc", pc_q, 32'd0);
    chk("rst_ir", ir_q, 32'd0);
    chk("rst_con", con_q, 1'b0);
    chk("rst_out", out_port, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    m_clear();
  endtask

  function automatic ctl_t rnd_ctl();
    ctl_t k;
    k = '0;
    for (int j = 0; j < 2; j++) begin
      if (j == 0 || $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 10))
          0: k.Rout = 1'b1;       1: k.BAout = 1'b1;     2: k.PCout = 1'b1;
          3: k.MDRout = 1'b1;     4: k.Zlowout = 1'b1;   5: k.Zhighout = 1'b1;
          6: k.HIout = 1'b1;      7: k.LOout = 1'b1;     8: k.IN_Portout = 1'b1;
          9: k.Cout = 1'b1;       default: ;
        endcase
      end
    end
    k.Gra = 1'($urandom_range(0, 1)); k.Grb = 1'($urandom_range(0, 1));
    k.Grc = 1'($urandom_range(0, 1));
    k.read  = 1'($urandom_range(0, 1));
    k.write = ($urandom_range(0, 4) == 0);
    k.MARIn = ($urandom_range(0, 3) == 0); k.PCIn  = ($urandom_range(0, 3) == 0);
    k.MDRIn = ($urandom_range(0, 3) == 0); k.IRIn  = ($urandom_range(0, 3) == 0);
    k.YIn   = ($urandom_range(0, 3) == 0); k.HiIn  = ($urandom_range(0, 3) == 0);
    k.LoIn  = ($urandom_range(0, 3) == 0); k.InIn  = ($urandom_range(0, 2) == 0);
    k.OutIn = ($urandom_range(0, 3) == 0); k.ZIn   = ($urandom_range(0, 2) == 0);
    k.CONIn = ($urandom_range(0, 3) == 0); k.RIn   = ($urandom_range(0, 3) == 0);
    k.CIn   = 1'($urandom_range(0, 1));
    k.IncPC = ($urandom_range(0, 7) == 0);
    k.add = ($urandom_range(0, 5) == 0); k.subtract = ($urandom_range(0, 5) == 0);
    k.multiply = ($urandom_range(0, 5) == 0); k.divide = ($urandom_range(0, 5) == 0);
    k.andSignal = ($urandom_range(0, 5) == 0); k.orSignal = ($urandom_range(0, 5) == 0);
    return k;
  endfunction

  initial begin
    ctl_t k;
    logic [31:0] v;
    c = '0;
    in_port_data = '0;
    clr = 1'b1;
    m_clear();
    for (int i = 0; i < 512; i++) m_mem[i] = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // fill RAM through MAR/MDR; word 0 holds the fetch test instruction
    for (int a = 0; a < 512; a++) begin
      v = (a == 0) ? 32'hA280_0000 : $urandom;
      k = '0; k.MARIn = 1'b1; put(32'(a), k);
      k = '0; k.MDRIn = 1'b1; put(v, k);
      k = '0; k.write = 1'b1; cyc(k, 32'd0);
    end
    do_reset();

    // fetch from PC=0
    k = '0; k.PCout = 1'b1; k.MARIn = 1'b1; k.IncPC = 1'b1; cyc(k, 0);
    k = '0; k.Zlowout = 1'b1; k.PCIn = 1'b1; k.MDRIn = 1'b1; k.read = 1'b1; cyc(k, 0);
    chk("fetch_pc", pc_q, 32'd1);
    k = '0; k.MDRout = 1'b1; k.IRIn = 1'b1; cyc(k, 0);
    chk("fetch_ir", ir_q, 32'hA280_0000);

    // jr R5
    k = '0; k.Gra = 1'b1; k.RIn = 1'b1; put(32'h40, k);
    k = '0; k.Gra = 1'b1; k.Rout = 1'b1; k.PCIn = 1'b1; cyc(k, 0);
    chk("jr_pc", pc_q, 32'h40);

    // add / subtract with Y=5, R3=7
    k = '0; k.IRIn = 1'b1; put(32'd3 << 23, k);
    k = '0; k.Gra = 1'b1; k.RIn = 1'b1; put(32'd7, k);
    k = '0; k.YIn = 1'b1; put(32'd5, k);
    k = '0; k.Gra = 1'b1; k.Rout = 1'b1; k.add = 1'b1; k.ZIn = 1'b1; cyc(k, 0);
    k = '0; k.Zlowout = 1'b1; cyc(k, 0); chk("add_zlo", bus_seen, 32'd12);
    k = '0; k.Gra = 1'b1; k.Rout = 1'b1; k.subtract = 1'b1; k.ZIn = 1'b1; cyc(k, 0);
    k = '0; k.Zlowout = 1'b1; cyc(k, 0); chk("sub_zlo", bus_seen, 32'hFFFF_FFFE);
    k = '0; k.Zhighout = 1'b1; cyc(k, 0); chk("sub_zhi", bus_seen, 32'd0);

    // multiply -1 * 2
    k = '0; k.YIn = 1'b1; put(32'hFFFF_FFFF, k);
    k = '0; k.multiply = 1'b1; k.ZIn = 1'b1; put(32'd2, k);
    k = '0; k.Zlowout = 1'b1; cyc(k, 0); chk("mul_zlo", bus_seen, 32'hFFFF_FFFE);
    k = '0; k.Zhighout = 1'b1; cyc(k, 0); chk("mul_zhi", bus_seen, 32'hFFFF_FFFF);

    // divide 7 / -2, then 7 / 0
    k = '0; k.YIn = 1'b1; put(32'd7, k);
    k = '0; k.divide = 1'b1; k.ZIn = 1'b1; put(32'hFFFF_FFFE, k);
    k = '0; k.Zlowout = 1'b1; cyc(k, 0); chk("div_q", bus_seen, 32'hFFFF_FFFD);
    k = '0; k.Zhighout = 1'b1; cyc(k, 0); chk("div_r", bus_seen, 32'd1);
    k = '0; k.divide = 1'b1; k.ZIn = 1'b1; put(32'd0, k);
    k = '0; k.Zlowout = 1'b1; cyc(k, 0); chk("div0_q", bus_seen, 32'hFFFF_FFFF);
    k = '0; k.Zhighout = 1'b1; cyc(k, 0); chk("div0_r", bus_seen, 32'd7);

    // C sign extension and bus priority
    k = '0; k.IRIn = 1'b1; put(32'h0004_0005, k);
    k = '0; k.Cout = 1'b1; cyc(k, 0); chk("c_sext", bus_seen, 32'hFFFC_0005);
    k = '0; k.Cout = 1'b1; k.PCout = 1'b1; cyc(k, 0); chk("prio_pc", bus_seen, 32'h40);

    // R0 is writable; BAout reads it as zero
    k = '0; k.RIn = 1'b1; put(32'h1234, k);
    k = '0; k.Rout = 1'b1; cyc(k, 0); chk("r0_rout", bus_seen, 32'h1234);
    k = '0; k.BAout = 1'b1; cyc(k, 0); chk("r0_baout", bus_seen, 32'd0);

    // CON: R2==0 with cond 00, then R2=5 with cond 11
    k = '0; k.IRIn = 1'b1; put(32'd2 << 23, k);
    k = '0; k.Gra = 1'b1; k.RIn = 1'b1; put(32'd0, k);
    k = '0; k.Gra = 1'b1; k.Rout = 1'b1; k.CONIn = 1'b1; cyc(k, 0);
    chk("con_eq0", con_q, 1'b1);
    k = '0; k.IRIn = 1'b1; put((32'd2 << 23) | (32'd3 << 19), k);
    k = '0; k.Gra = 1'b1; k.RIn = 1'b1; put(32'd5, k);
    k = '0; k.Gra = 1'b1; k.Rout = 1'b1; k.CONIn = 1'b1; cyc(k, 0);
    chk("con_lt0", con_q, 1'b0);

    // output port
    k = '0; k.OutIn = 1'b1; put(32'hCAFE_F00D, k);
    chk("out_port_ld", out_port, 32'hCAFE_F00D);

    // mid-run clear; RAM must keep word 0
    do_reset();
    k = '0; k.MDRIn = 1'b1; k.read = 1'b1; cyc(k, 0);
    k = '0; k.MDRout = 1'b1; cyc(k, 0); chk("ram_keep", bus_seen, 32'hA280_0000);

    // random strobe patterns
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) do_reset();
      cyc(rnd_ctl(), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
